// File: rtl/output_port_demux_pkg.sv
// output_port_demux_pkg: shared constants, state encoding and width helper for the output demux
package output_port_demux_pkg;
  localparam logic [7:0] IOQ_CTRL = 8'hFF;
  localparam int DST_LSB = 48;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/output_port_demux_small_fifo.sv
// small_fifo: first-word-fall-through FIFO whose head word is visible before it is popped
module small_fifo #(
  parameter int WIDTH = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] NEARLY = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0] depth;
  assign dout = mem[rd_ptr];
  assign empty = depth == '0;
  assign nearly_full = depth >= NEARLY;
  // storage is never reset; the pointers alone define which entries are valid
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(wr_en);
      rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(rd_en);
      depth  <= depth + (MAX_DEPTH_BITS + 1)'(wr_en) - (MAX_DEPTH_BITS + 1)'(rd_en);
    end
endmodule

// File: rtl/output_port_demux.sv
// output_port_demux: steers each buffered packet to the output queues selected by its IOQ header
module output_port_demux #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = output_port_demux_pkg::IOQ_CTRL,
  parameter int DST_LSB = output_port_demux_pkg::DST_LSB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [NUM_QUEUES-1:0] out_wr,
  input  logic [NUM_QUEUES-1:0] out_rdy,
  output logic [31:0]           pkt_fwd_count,
  output logic [31:0]           pkt_drop_count
);
  import output_port_demux_pkg::*;
  localparam int W = DATA_WIDTH + CTRL_WIDTH;
  state_t state;
  logic [W-1:0] head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [NUM_QUEUES-1:0] dst_mask, dst_field;
  logic empty, nearly_full, prev_ctrl_zero, move, pop, eop, hdr_ok;
  assign {head_ctrl, head_data} = head;
  assign dst_field = head_data[DST_LSB +: NUM_QUEUES];
  assign hdr_ok = head_ctrl == IOQ_CTRL && dst_field != '0;
  assign move = state == FWD && !empty && (out_rdy & dst_mask) == dst_mask;
  assign pop = move || (state == DROP && !empty);
  assign eop = head_ctrl != '0 && prev_ctrl_zero;
  assign in_rdy = !nearly_full;
  small_fifo #(
    .WIDTH(W),
    .MAX_DEPTH_BITS(log2(FIFO_DEPTH))
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .din({in_ctrl, in_data}),
    .wr_en(in_wr),
    .rd_en(pop),
    .dout(head),
    .nearly_full(nearly_full),
    .empty(empty)
  );
  // packet FSM: inspect header in IDLE, then forward or discard words up to and including EOP
  always_ff @(posedge clk)
    if (reset) begin
      state          <= IDLE;
      dst_mask       <= '0;
      prev_ctrl_zero <= 1'b0;
      out_wr         <= '0;
      out_data       <= '0;
      out_ctrl       <= '0;
      pkt_fwd_count  <= '0;
      pkt_drop_count <= '0;
    end else begin
      out_data <= head_data;
      out_ctrl <= head_ctrl;
      out_wr   <= move ? dst_mask : '0;
      if (pop) prev_ctrl_zero <= eop ? 1'b0 : head_ctrl == '0;
      if (move && eop) pkt_fwd_count <= pkt_fwd_count + 32'd1;
      case (state)
        IDLE:
          if (!empty) begin
            if (hdr_ok) begin
              dst_mask <= dst_field;
              state    <= FWD;
            end else begin
              pkt_drop_count <= pkt_drop_count + 32'd1;
              state          <= DROP;
            end
          end
        FWD, DROP:
          if (pop && eop) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
endmodule
